alu_rs: RTL and testbench

- Reservation station that schedules integer/branch/JALR micro-ops onto the single combinational ALU.
- Receives issued ops from the decoder/dispatcher and holds them until both operands are ready.
- Captures operands from the two CDB broadcast buses: the ALU result and the LSB result.
- Each cycle, selects at most one ready entry and drives the ALU input bundle through registered outputs.

---
 rtl/alu_rs.sv | 142 ++++++++++++++
 tb/tb_alu_rs.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs.sv
// Reservation station feeding the single-cycle ALU: holds issued ops until both
// operands are captured, then dispatches the lowest-index ready entry each cycle.
module alu_rs #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3,
  parameter int ROB_W = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clr_in,
  input  logic             iss_valid,
  input  logic [5:0]       iss_opcode,
  input  logic [31:0]      iss_vj,
  input  logic [31:0]      iss_vk,
  input  logic             iss_qj_busy,
  input  logic             iss_qk_busy,
  input  logic [ROB_W-1:0] iss_qj,
  input  logic [ROB_W-1:0] iss_qk,
  input  logic [ROB_W-1:0] iss_rob,
  output logic             rs_full,
  input  logic             alu_cdb_valid,
  input  logic [ROB_W-1:0] alu_cdb_rob,
  input  logic [31:0]      alu_cdb_val,
  input  logic             lsb_cdb_valid,
  input  logic [ROB_W-1:0] lsb_cdb_rob,
  input  logic [31:0]      lsb_cdb_val,
  output logic             alu_flag,
  output logic [5:0]       alu_opcode,
  output logic [31:0]      alu_val1,
  output logic [31:0]      alu_val2,
  output logic [ROB_W-1:0] alu_rob
);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] qj_busy;
  logic [DEPTH-1:0] qk_busy;
  logic [5:0]       op_q  [DEPTH];
  logic [31:0]      vj_q  [DEPTH];
  logic [31:0]      vk_q  [DEPTH];
  logic [ROB_W-1:0] qj_q  [DEPTH];
  logic [ROB_W-1:0] qk_q  [DEPTH];
  logic [ROB_W-1:0] rob_q [DEPTH];

  logic [DEPTH-1:0] ready;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;

  // Operand snoop shared by issue bypass and wakeup; the ALU bus wins a tie.
  function automatic logic [32:0] snoop(
    input logic             pend,
    input logic [ROB_W-1:0] tag,
    input logic [31:0]      val,
    input logic             a_v,
    input logic [ROB_W-1:0] a_rob,
    input logic [31:0]      a_val,
    input logic             l_v,
    input logic [ROB_W-1:0] l_rob,
    input logic [31:0]      l_val
  );
    logic [32:0] res;
    res = {pend, val};
    if (pend && a_v && (tag == a_rob)) res = {1'b0, a_val};
    else if (pend && l_v && (tag == l_rob)) res = {1'b0, l_val};
    return res;
  endfunction

  assign ready   = busy & ~qj_busy & ~qk_busy;
  assign rs_full = &busy;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    sel_found  = 1'b0;
    sel_idx    = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (ready[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      busy       <= '0;
      alu_flag   <= 1'b0;
      alu_opcode <= '0;
      alu_val1   <= '0;
      alu_val2   <= '0;
      alu_rob    <= '0;
    end else if (rdy_in) begin
      if (clr_in) begin
        busy     <= '0;
        alu_flag <= 1'b0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (busy[i]) begin
            {qj_busy[i], vj_q[i]} <= snoop(qj_busy[i], qj_q[i], vj_q[i],
                                           alu_cdb_valid, alu_cdb_rob, alu_cdb_val,
                                           lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_val);
            {qk_busy[i], vk_q[i]} <= snoop(qk_busy[i], qk_q[i], vk_q[i],
                                           alu_cdb_valid, alu_cdb_rob, alu_cdb_val,
                                           lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_val);
          end
        end
        // dispatch stage: registered bundle toward the ALU
        if (sel_found) begin
          alu_flag      <= 1'b1;
          alu_opcode    <= op_q[sel_idx];
          alu_val1      <= vj_q[sel_idx];
          alu_val2      <= vk_q[sel_idx];
          alu_rob       <= rob_q[sel_idx];
          busy[sel_idx] <= 1'b0;
        end else begin
          alu_flag <= 1'b0;
        end
        // free slot comes from registered busy, so the dispatching slot is never reused here
        if (iss_valid && free_found) begin
          busy[free_idx]  <= 1'b1;
          op_q[free_idx]  <= iss_opcode;
          qj_q[free_idx]  <= iss_qj;
          qk_q[free_idx]  <= iss_qk;
          rob_q[free_idx] <= iss_rob;
          {qj_busy[free_idx], vj_q[free_idx]} <= snoop(iss_qj_busy, iss_qj, iss_vj,
                                                       alu_cdb_valid, alu_cdb_rob, alu_cdb_val,
                                                       lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_val);
          {qk_busy[free_idx], vk_q[free_idx]} <= snoop(iss_qk_busy, iss_qk, iss_vk,
                                                       alu_cdb_valid, alu_cdb_rob, alu_cdb_val,
                                                       lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_val);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: directed vector table, hand-written full/priority sequence,
// and randomized traffic against an entry-list reference model.
module tb_alu_rs;
  localparam logic [5:0] ADD = 6'd1;
  localparam logic [5:0] SUB = 6'd2;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clr_in, iss_valid;
  logic [5:0]  iss_opcode;
  logic [31:0] iss_vj, iss_vk;
  logic        iss_qj_busy, iss_qk_busy;
  logic [3:0]  iss_qj, iss_qk, iss_rob;
  logic        rs_full;
  logic        alu_cdb_valid, lsb_cdb_valid;
  logic [3:0]  alu_cdb_rob, lsb_cdb_rob;
  logic [31:0] alu_cdb_val, lsb_cdb_val;
  logic        alu_flag;
  logic [5:0]  alu_opcode;
  logic [31:0] alu_val1, alu_val2;
  logic [3:0]  alu_rob;

  alu_rs #(.DEPTH(8), .IDX_W(3), .ROB_W(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
    .iss_valid(iss_valid), .iss_opcode(iss_opcode), .iss_vj(iss_vj), .iss_vk(iss_vk),
    .iss_qj_busy(iss_qj_busy), .iss_qk_busy(iss_qk_busy), .iss_qj(iss_qj), .iss_qk(iss_qk),
    .iss_rob(iss_rob), .rs_full(rs_full),
    .alu_cdb_valid(alu_cdb_valid), .alu_cdb_rob(alu_cdb_rob), .alu_cdb_val(alu_cdb_val),
    .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_rob(lsb_cdb_rob), .lsb_cdb_val(lsb_cdb_val),
    .alu_flag(alu_flag), .alu_opcode(alu_opcode), .alu_val1(alu_val1), .alu_val2(alu_val2),
    .alu_rob(alu_rob)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        rst, rdy, clr, iv;
    logic [5:0]  op;
    logic [31:0] vj, vk;
    logic        jb, kb;
    logic [3:0]  qj, qk, rob;
    logic        av;
    logic [3:0]  ar;
    logic [31:0] aval;
    logic        lv;
    logic [3:0]  lr;
    logic [31:0] lval;
    logic        e_flag, e_full, chk_b;
    logic [5:0]  e_op;
    logic [31:0] e_v1, e_v2;
    logic [3:0]  e_rob;
  } vec_t;

  typedef struct {
    logic        v;
    logic [5:0]  op;
    logic [31:0] vj, vk;
    logic        jb, kb;
    logic [3:0]  qj, qk, rob;
  } ment_t;

  int tests = 0;
  int fails = 0;

  ment_t       m [8];
  logic        mf;
  logic [5:0]  mop;
  logic [31:0] mv1, mv2;
  logic [3:0]  mrob;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t idle();
    vec_t v;
    v = '{default: 0};
    v.rst = 1'b1;
    v.rdy = 1'b1;
    return v;
  endfunction

  function automatic vec_t issue(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                                 input logic jb, input logic [3:0] qj, input logic kb,
                                 input logic [3:0] qk, input logic [3:0] rob);
    vec_t v;
    v = idle();
    v.iv = 1'b1; v.op = op; v.vj = vj; v.vk = vk;
    v.jb = jb; v.qj = qj; v.kb = kb; v.qk = qk; v.rob = rob;
    return v;
  endfunction

  function automatic vec_t expb(input vec_t vin, input logic flag, input logic [5:0] op,
                                input logic [31:0] v1, input logic [31:0] v2, input logic [3:0] rob);
    vec_t v;
    v = vin;
    v.chk_b = 1'b1; v.e_flag = flag; v.e_op = op; v.e_v1 = v1; v.e_v2 = v2; v.e_rob = rob;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst_in = v.rst; rdy_in = v.rdy; clr_in = v.clr;
    iss_valid = v.iv; iss_opcode = v.op; iss_vj = v.vj; iss_vk = v.vk;
    iss_qj_busy = v.jb; iss_qk_busy = v.kb; iss_qj = v.qj; iss_qk = v.qk; iss_rob = v.rob;
    alu_cdb_valid = v.av; alu_cdb_rob = v.ar; alu_cdb_val = v.aval;
    lsb_cdb_valid = v.lv; lsb_cdb_rob = v.lr; lsb_cdb_val = v.lval;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // A pending operand picks up a broadcast carrying its tag; the ALU bus is looked at first.
  function automatic ment_t wake(input ment_t e, input vec_t v);
    ment_t r;
    r = e;
    if (r.jb && v.av && v.ar == r.qj) begin r.jb = 1'b0; r.vj = v.aval; end
    else if (r.jb && v.lv && v.lr == r.qj) begin r.jb = 1'b0; r.vj = v.lval; end
    if (r.kb && v.av && v.ar == r.qk) begin r.kb = 1'b0; r.vk = v.aval; end
    else if (r.kb && v.lv && v.lr == r.qk) begin r.kb = 1'b0; r.vk = v.lval; end
    return r;
  endfunction

  task automatic model_step(input vec_t v);
    int sel, fr;
    ment_t ne;
    if (!v.rst) begin
      foreach (m[i]) m[i].v = 1'b0;
      mf = 1'b0; mop = '0; mv1 = '0; mv2 = '0; mrob = '0;
    end else if (v.rdy) begin
      if (v.clr) begin
        foreach (m[i]) m[i].v = 1'b0;
        mf = 1'b0;
      end else begin
        sel = -1;
        fr  = -1;
        foreach (m[i]) begin
          if (sel < 0 && m[i].v && !m[i].jb && !m[i].kb) sel = i;
          if (fr < 0 && !m[i].v) fr = i;
        end
        foreach (m[i]) if (m[i].v) m[i] = wake(m[i], v);
        if (sel >= 0) begin
          mf = 1'b1; mop = m[sel].op; mv1 = m[sel].vj; mv2 = m[sel].vk; mrob = m[sel].rob;
          m[sel].v = 1'b0;
        end else begin
          mf = 1'b0;
        end
        if (v.iv && fr >= 0) begin
          ne = '{v: 1'b1, op: v.op, vj: v.vj, vk: v.vk, jb: v.jb, kb: v.kb,
                 qj: v.qj, qk: v.qk, rob: v.rob};
          m[fr] = wake(ne, v);
        end
      end
    end
  endtask

  function automatic logic model_full();
    logic f;
    f = 1'b1;
    foreach (m[i]) if (!m[i].v) f = 1'b0;
    return f;
  endfunction

  initial begin
    vec_t tbl[$];
    vec_t v;

    // ---------------- directed vector table ----------------
    v = idle(); v.rst = 1'b0;
    tbl.push_back(expb(v, 1'b0, 6'd0, 32'd0, 32'd0, 4'd0));
    tbl.push_back(issue(ADD, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3));
    tbl.push_back(expb(idle(), 1'b1, ADD, 32'd5, 32'd7, 4'd3));
    tbl.push_back(expb(idle(), 1'b0, ADD, 32'd5, 32'd7, 4'd3));
    tbl.push_back(issue(SUB, 32'd0, 32'd1, 1'b1, 4'd2, 1'b0, 4'd0, 4'd4));
    tbl.push_back(idle());
    v = idle(); v.lv = 1'b1; v.lr = 4'd2; v.lval = 32'd10;
    tbl.push_back(v);
    tbl.push_back(expb(idle(), 1'b1, SUB, 32'd10, 32'd1, 4'd4));
    tbl.push_back(idle());
    v = issue(ADD, 32'd3, 32'd0, 1'b0, 4'd0, 1'b1, 4'd5, 4'd6);
    v.av = 1'b1; v.ar = 4'd5; v.aval = 32'hFFFF_FFFF;
    tbl.push_back(v);
    tbl.push_back(expb(idle(), 1'b1, ADD, 32'd3, 32'hFFFF_FFFF, 4'd6));
    tbl.push_back(idle());
    for (int k = 0; k < 4; k++)
      tbl.push_back(issue(SUB, 32'd0, 32'(k), 1'b1, 4'(8 + k), 1'b0, 4'd0, 4'(k)));
    tbl.push_back(issue(ADD, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd7));
    v = issue(ADD, 32'd9, 32'd9, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
    v.clr = 1'b1; v.av = 1'b1; v.ar = 4'd8; v.aval = 32'd1;
    tbl.push_back(v);
    for (int k = 0; k < 4; k++) begin
      v = idle();
      if (k % 2 == 0) begin v.av = 1'b1; v.ar = 4'(8 + k); v.aval = 32'd5; end
      else begin v.lv = 1'b1; v.lr = 4'(8 + k); v.lval = 32'd6; end
      tbl.push_back(v);
    end
    tbl.push_back(idle());
    tbl.push_back(issue(ADD, 32'd20, 32'd22, 1'b0, 4'd0, 1'b0, 4'd0, 4'd5));
    v = issue(ADD, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9); v.rdy = 1'b0;
    tbl.push_back(v);
    v = idle(); v.rdy = 1'b0;
    tbl.push_back(v);
    tbl.push_back(v);
    tbl.push_back(expb(idle(), 1'b1, ADD, 32'd20, 32'd22, 4'd5));
    tbl.push_back(idle());
    tbl.push_back(issue(SUB, 32'd0, 32'd3, 1'b1, 4'd12, 1'b0, 4'd0, 4'd1));
    tbl.push_back(issue(ADD, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd2));
    v = idle(); v.rst = 1'b0; v.lv = 1'b1; v.lr = 4'd12; v.lval = 32'd4;
    tbl.push_back(expb(v, 1'b0, 6'd0, 32'd0, 32'd0, 4'd0));
    v = idle(); v.lv = 1'b1; v.lr = 4'd12; v.lval = 32'd4;
    tbl.push_back(v);
    tbl.push_back(idle());
    tbl.push_back(idle());

    foreach (tbl[i]) begin
      drive(tbl[i]);
      tick();
      chk($sformatf("vec%0d_flag", i), 32'(alu_flag), 32'(tbl[i].e_flag));
      chk($sformatf("vec%0d_full", i), 32'(rs_full), 32'(tbl[i].e_full));
      if (tbl[i].chk_b) begin
        chk($sformatf("vec%0d_op", i), 32'(alu_opcode), 32'(tbl[i].e_op));
        chk($sformatf("vec%0d_v1", i), alu_val1, tbl[i].e_v1);
        chk($sformatf("vec%0d_v2", i), alu_val2, tbl[i].e_v2);
        chk($sformatf("vec%0d_rob", i), 32'(alu_rob), 32'(tbl[i].e_rob));
      end
    end

    // ---------------- full / priority sequence ----------------
    v = idle(); v.rst = 1'b0;
    drive(v); tick();
    for (int k = 0; k < 8; k++) begin
      drive(issue(SUB, 32'd0, 32'(100 * k), 1'b1, 4'(k), 1'b0, 4'd0, 4'(k)));
      tick();
    end
    chk("full_after8", 32'(rs_full), 32'd1);
    drive(issue(ADD, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd15));
    tick();
    chk("full_drop9", 32'(rs_full), 32'd1);
    drive(idle()); tick();
    chk("drop9_nodisp", 32'(alu_flag), 32'd0);
    v = idle(); v.av = 1'b1; v.ar = 4'd6; v.aval = 32'h66; v.lv = 1'b1; v.lr = 4'd2; v.lval = 32'h22;
    drive(v); tick();
    chk("wake_flag", 32'(alu_flag), 32'd0);
    chk("wake_full", 32'(rs_full), 32'd1);
    drive(idle()); tick();
    chk("pri1_flag", 32'(alu_flag), 32'd1);
    chk("pri1_rob", 32'(alu_rob), 32'd2);
    chk("pri1_v1", alu_val1, 32'h22);
    chk("pri1_v2", alu_val2, 32'd200);
    chk("pri1_full", 32'(rs_full), 32'd0);
    tick();
    chk("pri2_flag", 32'(alu_flag), 32'd1);
    chk("pri2_rob", 32'(alu_rob), 32'd6);
    chk("pri2_v1", alu_val1, 32'h66);
    chk("pri2_v2", alu_val2, 32'd600);
    tick();
    chk("pri3_flag", 32'(alu_flag), 32'd0);

    // ---------------- randomized against the model ----------------
    v = idle(); v.rst = 1'b0;
    drive(v); model_step(v); tick();
    for (int c = 0; c < 1500; c++) begin
      v = idle();
      v.rst  = ($urandom_range(0, 99) != 0);
      v.rdy  = ($urandom_range(0, 7) != 0);
      v.clr  = ($urandom_range(0, 39) == 0);
      v.iv   = ($urandom_range(0, 1) == 1);
      v.op   = 6'($urandom_range(0, 63));
      v.vj   = $urandom;
      v.vk   = $urandom;
      v.jb   = ($urandom_range(0, 1) == 1);
      v.kb   = ($urandom_range(0, 1) == 1);
      v.qj   = 4'($urandom_range(0, 7));
      v.qk   = 4'($urandom_range(0, 7));
      v.rob  = 4'($urandom_range(0, 15));
      v.av   = ($urandom_range(0, 2) == 0);
      v.ar   = 4'($urandom_range(0, 7));
      v.aval = $urandom;
      v.lv   = ($urandom_range(0, 2) == 0);
      v.lr   = 4'($urandom_range(0, 7));
      v.lval = $urandom;
      if (v.av && v.lv && v.lr == v.ar) v.lr = v.ar ^ 4'd1;
      drive(v);
      model_step(v);
      tick();
      chk($sformatf("rnd%0d_flag", c), 32'(alu_flag), 32'(mf));
      chk($sformatf("rnd%0d_full", c), 32'(rs_full), 32'(model_full()));
      chk($sformatf("rnd%0d_op", c), 32'(alu_opcode), 32'(mop));
      chk($sformatf("rnd%0d_v1", c), alu_val1, mv1);
      chk($sformatf("rnd%0d_v2", c), alu_val2, mv2);
      chk($sformatf("rnd%0d_rob", c), 32'(alu_rob), 32'(mrob));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
